// File: rtl/display_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with blanking gaps and
// double-buffered digit data that commits only at frame boundaries.
module display_scan_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SHOW_CYCLES  = 100_000,
    parameter int unsigned BLANK_CYCLES = 1_000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     digit_en,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      load_ack,
    output logic                      frame_done
);

    localparam int unsigned MaxCycles = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);
    localparam int unsigned IdxW      = $clog2(NUM_DIGITS);

    localparam logic [CntW-1:0] BlankLoad = CntW'(BLANK_CYCLES);
    localparam logic [CntW-1:0] ShowLoad  = CntW'(SHOW_CYCLES);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DIGITS - 1);
    localparam logic [IdxW-1:0] IdxOne    = IdxW'(1);

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StShow  = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [CntW-1:0]         cnt_q, cnt_d, blank_left;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] active_digits_q, shadow_digits_q;
    logic [NUM_DIGITS-1:0]   active_dp_q, shadow_dp_q;
    logic [NUM_DIGITS-1:0]   active_en_q, shadow_en_q;
    logic                    pending_q;

    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    load_ack_q, frame_done_q;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // A zero count only occurs straight out of reset and stands for a fresh blank slot.
    assign blank_left = (cnt_q == '0) ? BlankLoad : cnt_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        if (state_q == StBlank) begin
            if (blank_left <= CntOne) begin
                state_d = StShow;
                cnt_d   = ShowLoad;
            end else begin
                cnt_d = blank_left - CntOne;
            end
        end else begin
            if (cnt_q <= CntOne) begin
                state_d = StBlank;
                cnt_d   = BlankLoad;
                idx_d   = (idx_q == LastIdx) ? '0 : idx_q + IdxOne;
            end else begin
                cnt_d = cnt_q - CntOne;
            end
        end
    end

    // The boundary edge is the one entering the last SHOW cycle of the last digit.
    assign boundary = (state_d == StShow) && (idx_d == LastIdx) && (cnt_d == CntOne);

    // Outputs use the pre-commit active data, so the committing frame's tail is unaffected.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == StShow) begin
            if (active_en_q[idx_d]) an_d[idx_d] = 1'b0;
            seg_d = hex7(active_digits_q[{idx_d, 2'b00} +: 4]);
            dp_d  = ~active_dp_q[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StBlank;
            idx_q           <= '0;
            cnt_q           <= '0;
            active_digits_q <= '0;
            active_dp_q     <= '0;
            active_en_q     <= '1;  // zeros are visible out of reset
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            shadow_en_q     <= '0;
            pending_q       <= 1'b0;
            an_q            <= '1;
            seg_q           <= 7'h7F;
            dp_q            <= 1'b1;
            load_ack_q      <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= boundary;
            load_ack_q   <= boundary && (load || pending_q);
            if (boundary) begin
                if (load) begin
                    active_digits_q <= digits_in;
                    active_dp_q     <= dp_in;
                    active_en_q     <= digit_en;
                end else if (pending_q) begin
                    active_digits_q <= shadow_digits_q;
                    active_dp_q     <= shadow_dp_q;
                    active_en_q     <= shadow_en_q;
                end
                pending_q <= 1'b0;
            end else if (load) begin
                shadow_digits_q <= digits_in;
                shadow_dp_q     <= dp_in;
                shadow_en_q     <= digit_en;
                pending_q       <= 1'b1;
            end
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign load_ack   = load_ack_q;
    assign frame_done = frame_done_q;

endmodule
